fwd_hazard_unit: RTL and testbench



---
 rtl/fwd_hazard_unit.sv | 146 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks destination-register metadata for the ID/EX,
// EX/MEM and MEM/WB slots. It produces EX operand forward selects, detects
// load-use hazards (one-cycle ID stall plus bubble) and counts stall cycles.
// Only register indices and control bits pass through this block.
module fwd_hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        ex_flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] stall_count
);

  localparam logic [1:0] SEL_RF    = 2'd0;
  localparam logic [1:0] SEL_EXMEM = 2'd1;
  localparam logic [1:0] SEL_MEMWB = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } idex_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } exmem_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
  } memwb_t;

  idex_t       idex_q;
  idex_t       idex_d;
  exmem_t      exmem_q;
  memwb_t      memwb_q;
  logic [31:0] stall_count_q;
  logic        load_use;

  // A slot is a forwarding source for r only if it really writes r; x0 never is.
  function automatic logic slot_writes(input logic valid, input logic reg_write,
                                       input logic [4:0] rd, input logic [4:0] r);
    return valid && reg_write && (rd == r) && (rd != 5'd0);
  endfunction

  // Load-use hazard: the load in ID/EX produces a register the ID instruction reads.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_use = 1'b0;
    if (idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0)) begin
      load_use = (id_rs1_used && (id_rs1 == idex_q.rd)) ||
                 (id_rs2_used && (id_rs2 == idex_q.rd));
    end
    // A flush kills the ID instruction, so there is nothing left to stall for.
    stall = id_valid && !ex_flush && load_use;
  end

  // Next ID/EX contents: the ID instruction, or an all-zero bubble.
  always_comb begin
    idex_d = '0;
    if (id_valid && !stall && !ex_flush) begin
      idex_d.valid     = 1'b1;
      idex_d.rs1       = id_rs1;
      idex_d.rs2       = id_rs2;
      idex_d.rs1_used  = id_rs1_used;
      idex_d.rs2_used  = id_rs2_used;
      idex_d.rd        = id_rd;
      idex_d.reg_write = id_reg_write;
      idex_d.mem_read  = id_mem_read;
    end
  end

  // Slot advance and saturating stall counter; older slots never stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every slot samples the old values.
    if (!rst_n) begin
      idex_q        <= '0;
      exmem_q       <= '0;
      memwb_q       <= '0;
      stall_count_q <= '0;
    end else begin
      idex_q            <= idex_d;
      exmem_q.valid     <= idex_q.valid;
      exmem_q.rd        <= idex_q.rd;
      exmem_q.reg_write <= idex_q.reg_write;
      exmem_q.mem_read  <= idex_q.mem_read;
      memwb_q.valid     <= exmem_q.valid;
      memwb_q.rd        <= exmem_q.rd;
      memwb_q.reg_write <= exmem_q.reg_write;
      if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  // Operand forward selects; EX/MEM wins over MEM/WB as the younger producer.
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (idex_q.valid && idex_q.rs1_used) begin
      if (slot_writes(exmem_q.valid, exmem_q.reg_write, exmem_q.rd, idex_q.rs1)) begin
        fwd_a_sel = SEL_EXMEM;
      end else if (slot_writes(memwb_q.valid, memwb_q.reg_write, memwb_q.rd, idex_q.rs1)) begin
        fwd_a_sel = SEL_MEMWB;
      end
    end
    if (idex_q.valid && idex_q.rs2_used) begin
      if (slot_writes(exmem_q.valid, exmem_q.reg_write, exmem_q.rd, idex_q.rs2)) begin
        fwd_b_sel = SEL_EXMEM;
      end else if (slot_writes(memwb_q.valid, memwb_q.reg_write, memwb_q.rd, idex_q.rs2)) begin
        fwd_b_sel = SEL_MEMWB;
      end
    end
  end

  // A load sitting in EX/MEM has no data yet, so it must never be selected.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(exmem_q.valid && exmem_q.mem_read) ||
              ((fwd_a_sel != SEL_EXMEM) && (fwd_b_sel != SEL_EXMEM)));
    end
  end

  assign ex_valid    = idex_q.valid;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed stimulus for fwd_hazard_unit. Each step drives
// the ID inputs, pushes the expected outputs for that cycle to a scoreboard
// and pops/compares them once the combinational outputs have settled.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        ex_flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        stall;
  logic        ex_valid;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .ex_flush     (ex_flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .stall_count  (stall_count)
  );

  typedef struct {
    string       tag;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        st;
    logic        ev;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp   = 0;
  int          n_bad   = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    id_valid     = 1'b1;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_rs1       = rs1;
    id_rs1_used  = u1;
    id_rs2       = rs2;
    id_rs2_used  = u2;
  endtask

  task automatic nop();
    id_valid     = 1'b0;
    id_rd        = 5'd0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    id_rs1       = 5'd0;
    id_rs1_used  = 1'b0;
    id_rs2       = 5'd0;
    id_rs2_used  = 1'b0;
  endtask

  task automatic rand_id();
    id_valid     = 1'($urandom);
    id_rd        = 5'($urandom);
    id_reg_write = 1'($urandom);
    id_mem_read  = 1'($urandom);
    id_rs1       = 5'($urandom);
    id_rs1_used  = 1'($urandom);
    id_rs2       = 5'($urandom);
    id_rs2_used  = 1'($urandom);
    ex_flush     = 1'($urandom);
  endtask

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, "/fwd_a_sel"},   32'(fwd_a_sel), 32'(e.a));
    check({e.tag, "/fwd_b_sel"},   32'(fwd_b_sel), 32'(e.b));
    check({e.tag, "/stall"},       32'(stall),     32'(e.st));
    check({e.tag, "/ex_valid"},    32'(ex_valid),  32'(e.ev));
    check({e.tag, "/stall_count"}, stall_count,    e.cnt);
  endtask

  // Called just after a negedge with the ID inputs already driven.
  task automatic step(input string tag, input logic [1:0] a, input logic [1:0] b,
                      input logic st, input logic ev);
    exp_t e;
    e.tag = tag;
    e.a   = a;
    e.b   = b;
    e.st  = st;
    e.ev  = ev;
    e.cnt = exp_cnt;
    sb.push_back(e);
    #1;
    compare_out();
    if (!rst_n) exp_cnt = 32'd0;
    else if (st && (exp_cnt != 32'hFFFF_FFFF)) exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
  endtask

  // ld xr ; add x(r+1), xr, xr : one stall, one bubble, then MEM/WB forwarding.
  task automatic load_use(input string tag, input logic [4:0] r);
    drive(r, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
    step({tag, "_ld"}, 2'd0, 2'd0, 1'b0, 1'b0);
    drive(r + 5'd1, 1'b1, 1'b0, r, 1'b1, r, 1'b1);
    step({tag, "_stall"}, 2'd0, 2'd0, 1'b1, 1'b1);
    step({tag, "_bubble"}, 2'd0, 2'd0, 1'b0, 1'b0);
    nop();
    step({tag, "_fwd"}, 2'd2, 2'd2, 1'b0, 1'b1);
  endtask

  // Invariant: a load in EX/MEM is never chosen as an EX/MEM forwarding source.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && dut.exmem_q.valid === 1'b1 && dut.exmem_q.mem_read === 1'b1) begin
      n_cmp++;
      assert (fwd_a_sel !== 2'd1 && fwd_b_sel !== 2'd1) else begin
        n_bad++;
        $error("FAIL load_in_exmem_fwd: observed a=%0d b=%0d expected neither 1",
               fwd_a_sel, fwd_b_sel);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    ex_flush = 1'b0;
    nop();

    // Reset with random ID inputs.
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rand_id();
      step("reset", 2'd0, 2'd0, 1'b0, 1'b0);
    end
    rst_n    = 1'b1;
    ex_flush = 1'b0;
    nop();
    step("idle", 2'd0, 2'd0, 1'b0, 1'b0);

    // add x5 ; sub x6,x5,x7 ; and x9,x7,x5
    drive(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
    step("alu_add", 2'd0, 2'd0, 1'b0, 1'b0);
    drive(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1);
    step("alu_sub", 2'd0, 2'd0, 1'b0, 1'b1);
    drive(5'd9, 1'b1, 1'b0, 5'd7, 1'b1, 5'd5, 1'b1);
    step("alu_dist1", 2'd1, 2'd0, 1'b0, 1'b1);
    nop();
    step("alu_dist2", 2'd0, 2'd2, 1'b0, 1'b1);
    step("alu_drain", 2'd0, 2'd0, 1'b0, 1'b0);

    // Distance 3: producer, two empty slots, consumer reads the register file.
    drive(5'd20, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("d3_prod", 2'd0, 2'd0, 1'b0, 1'b0);
    nop();
    step("d3_gap1", 2'd0, 2'd0, 1'b0, 1'b1);
    step("d3_gap2", 2'd0, 2'd0, 1'b0, 1'b0);
    drive(5'd21, 1'b1, 1'b0, 5'd20, 1'b1, 5'd20, 1'b1);
    step("d3_cons", 2'd0, 2'd0, 1'b0, 1'b0);
    nop();
    step("d3_ex", 2'd0, 2'd0, 1'b0, 1'b1);
    step("d3_drain", 2'd0, 2'd0, 1'b0, 1'b0);

    // Load-use on x10.
    load_use("lu", 5'd10);

    // Load to x0 followed by a reader of x0: no stall, no forwarding.
    drive(5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
    step("x0_ld", 2'd0, 2'd0, 1'b0, 1'b0);
    drive(5'd1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    step("x0_use", 2'd0, 2'd0, 1'b0, 1'b1);
    nop();
    step("x0_ex", 2'd0, 2'd0, 1'b0, 1'b1);
    step("x0_drain", 2'd0, 2'd0, 1'b0, 1'b0);

    // Two producers of x3: EX/MEM has priority over MEM/WB.
    drive(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("pri_p1", 2'd0, 2'd0, 1'b0, 1'b0);
    drive(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("pri_p2", 2'd0, 2'd0, 1'b0, 1'b1);
    drive(5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b1);
    step("pri_cons", 2'd0, 2'd0, 1'b0, 1'b1);
    nop();
    step("pri_ex", 2'd1, 2'd0, 1'b0, 1'b1);
    step("pri_drain", 2'd0, 2'd0, 1'b0, 1'b0);

    // Flush while a load-use condition is present.
    drive(5'd12, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
    step("fl_ld", 2'd0, 2'd0, 1'b0, 1'b0);
    drive(5'd13, 1'b1, 1'b0, 5'd12, 1'b1, 5'd12, 1'b1);
    ex_flush = 1'b1;
    step("fl_hazard", 2'd0, 2'd0, 1'b0, 1'b1);
    ex_flush = 1'b0;
    nop();
    step("fl_bubble", 2'd0, 2'd0, 1'b0, 1'b0);

    // Reset arriving mid-stall clears the stall and the counter.
    drive(5'd14, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
    step("rs_ld", 2'd0, 2'd0, 1'b0, 1'b0);
    drive(5'd15, 1'b1, 1'b0, 5'd14, 1'b1, 5'd14, 1'b1);
    rst_n = 1'b0;
    step("rs_hazard", 2'd0, 2'd0, 1'b1, 1'b1);
    rst_n = 1'b1;
    step("rs_after", 2'd0, 2'd0, 1'b0, 1'b0);
    nop();
    step("rs_ex", 2'd0, 2'd0, 1'b0, 1'b1);
    step("rs_drain", 2'd0, 2'd0, 1'b0, 1'b0);

    // Counter saturation: preload near the top, then three load-use stalls.
    force dut.stall_count_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    step("sat_preload", 2'd0, 2'd0, 1'b0, 1'b0);
    release dut.stall_count_q;
    load_use("sat1", 5'd16);
    load_use("sat2", 5'd18);
    load_use("sat3", 5'd22);
    step("sat_hold", 2'd0, 2'd0, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
